// File: rtl/armleocpu_defs.sv
// Shared definitions for the burst RAM responder: bus widths, FSM state encoding
// and the burstcount normalisation helper.
package armleocpu_defs;

    localparam int BURSTCOUNT_W = 4;
    localparam int BUS_ADDR_W   = 34;

    typedef enum logic [1:0] {
        BURST_RAM_IDLE        = 2'd0,
        BURST_RAM_READ_BURST  = 2'd1,
        BURST_RAM_WRITE_BURST = 2'd2
    } burst_ram_state_t;

    // A burstcount of zero carries one beat.
    function automatic logic [BURSTCOUNT_W-1:0] burst_beats(input logic [BURSTCOUNT_W-1:0] bc);
        return (bc == '0) ? BURSTCOUNT_W'(1) : bc;
    endfunction

endpackage

// File: rtl/mem_1w1r.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and a write to the same address in one cycle returns the old contents.
module mem_1w1r #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

endmodule

// File: rtl/armleocpu_burst_ram.sv
// Burst-capable word RAM responder for the cache master bus.
// Optional ARMLEOCPU_BURST_RAM_STALL_INJECT_EN adds LFSR-driven waitrequest and read bubbles.
//
// state                 | meaning
// BURST_RAM_IDLE        | ready for a command; single-beat commands complete here
// BURST_RAM_READ_BURST  | issuing one RAM read per cycle, waitrequest held high
// BURST_RAM_WRITE_BURST | collecting remaining write beats, bubbles allowed
module armleocpu_burst_ram
    import armleocpu_defs::*;
#(
    parameter int          DEPTH_W   = 12,
    parameter logic [31:0] BASE_WORD = 32'd0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUS_ADDR_W-1:0]   m_address,
    input  logic [BURSTCOUNT_W-1:0] m_burstcount,
    output logic                    m_waitrequest,
    input  logic                    m_read,
    output logic [31:0]             m_readdata,
    output logic                    m_readdatavalid,
    input  logic                    m_write,
    input  logic [31:0]             m_writedata,
    input  logic [3:0]              m_byteenable
);

    burst_ram_state_t state, state_d;
    logic [DEPTH_W-1:0]      ptr, ptr_d;
    logic [BURSTCOUNT_W-1:0] remaining, remaining_d;
    logic                    in_range, in_range_d;
    logic                    rvalid, rd_ok;

    logic                    issue_rd, issue_rd_ok;
    logic                    ram_ren, ram_wen;
    logic [DEPTH_W-1:0]      ram_raddr, ram_waddr;
    logic [31:0]             ram_rdata;

    logic [31:0]             cmd_word, cmd_offset;
    logic                    cmd_in_range;
    logic [BURSTCOUNT_W-1:0] cmd_beats;
    logic                    stall_wait, stall_read;
    logic                    unused_addr_lsbs;

    assign unused_addr_lsbs = ^m_address[1:0];

    // Range is decided once from the first beat and applies to the whole burst.
    assign cmd_word     = m_address[BUS_ADDR_W-1:2];
    assign cmd_offset   = cmd_word - BASE_WORD;
    assign cmd_in_range = (cmd_word >= BASE_WORD) && ((cmd_offset >> DEPTH_W) == 32'd0);
    assign cmd_beats    = burst_beats(m_burstcount);

`ifdef ARMLEOCPU_BURST_RAM_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall_wait = lfsr[0];
    assign stall_read = lfsr[1];
`else
    assign stall_wait = 1'b0;
    assign stall_read = 1'b0;
`endif

    assign m_waitrequest = (state == BURST_RAM_READ_BURST) || stall_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BURST_RAM_IDLE;
            ptr       <= '0;
            remaining <= '0;
            in_range  <= 1'b0;
            rvalid    <= 1'b0;
            rd_ok     <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            remaining <= remaining_d;
            in_range  <= in_range_d;
            rvalid    <= issue_rd;
            rd_ok     <= issue_rd && issue_rd_ok;
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        remaining_d = remaining;
        in_range_d  = in_range;
        ram_ren     = 1'b0;
        ram_raddr   = ptr;
        ram_wen     = 1'b0;
        ram_waddr   = ptr;
        issue_rd    = 1'b0;
        issue_rd_ok = in_range;

        unique case (state)
            BURST_RAM_IDLE: begin
                if (!m_waitrequest && m_write) begin
                    ram_wen     = cmd_in_range;
                    ram_waddr   = cmd_offset[DEPTH_W-1:0];
                    ptr_d       = cmd_offset[DEPTH_W-1:0] + DEPTH_W'(1);
                    remaining_d = cmd_beats - BURSTCOUNT_W'(1);
                    in_range_d  = cmd_in_range;
                    if (cmd_beats != BURSTCOUNT_W'(1)) state_d = BURST_RAM_WRITE_BURST;
                end else if (!m_waitrequest && m_read) begin
                    ram_ren     = cmd_in_range;
                    ram_raddr   = cmd_offset[DEPTH_W-1:0];
                    issue_rd    = 1'b1;
                    issue_rd_ok = cmd_in_range;
                    ptr_d       = cmd_offset[DEPTH_W-1:0] + DEPTH_W'(1);
                    remaining_d = cmd_beats - BURSTCOUNT_W'(1);
                    in_range_d  = cmd_in_range;
                    if (cmd_beats != BURSTCOUNT_W'(1)) state_d = BURST_RAM_READ_BURST;
                end
            end
            BURST_RAM_READ_BURST: begin
                if (!stall_read) begin
                    ram_ren     = in_range;
                    issue_rd    = 1'b1;
                    ptr_d       = ptr + DEPTH_W'(1);
                    remaining_d = remaining - BURSTCOUNT_W'(1);
                    if (remaining == BURSTCOUNT_W'(1)) state_d = BURST_RAM_IDLE;
                end
            end
            BURST_RAM_WRITE_BURST: begin
                if (m_write && !m_waitrequest) begin
                    ram_wen     = in_range;
                    ptr_d       = ptr + DEPTH_W'(1);
                    remaining_d = remaining - BURSTCOUNT_W'(1);
                    if (remaining == BURSTCOUNT_W'(1)) state_d = BURST_RAM_IDLE;
                end
            end
            default: state_d = BURST_RAM_IDLE;
        endcase
    end

    assign m_readdatavalid = rvalid;
    assign m_readdata      = rd_ok ? ram_rdata : 32'd0;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mem_1w1r #(
            .ADDR_W (DEPTH_W),
            .DATA_W (8)
        ) u_mem (
            .clk   (clk),
            .wen   (ram_wen && m_byteenable[i]),
            .waddr (ram_waddr),
            .wdata (m_writedata[8*i +: 8]),
            .ren   (ram_ren),
            .raddr (ram_raddr),
            .rdata (ram_rdata[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_armleocpu_burst_ram.sv
// Randomized and directed bench for armleocpu_burst_ram against a flat word-array model.
// Honours ARMLEOCPU_BURST_RAM_STALL_INJECT_EN by relaxing only the cycle-exact timing checks.
module tb_armleocpu_burst_ram;

    localparam int          DEPTH_W   = 6;
    localparam int          DEPTH     = 1 << DEPTH_W;
    localparam logic [31:0] BASE_WORD = 32'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] m_address = '0;
    logic [3:0]  m_burstcount = '0;
    logic        m_waitrequest;
    logic        m_read = 1'b0;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic        m_write = 1'b0;
    logic [31:0] m_writedata = '0;
    logic [3:0]  m_byteenable = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] wdata_buf [16];
    logic [3:0]  be_buf [16];

    always #5 clk = ~clk;

    armleocpu_burst_ram #(
        .DEPTH_W   (DEPTH_W),
        .BASE_WORD (BASE_WORD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_address       (m_address),
        .m_burstcount    (m_burstcount),
        .m_waitrequest   (m_waitrequest),
        .m_read          (m_read),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_window(input logic [33:0] addr);
        logic [31:0] w0;
        w0 = addr[33:2];
        return (w0 >= BASE_WORD) && ((w0 - BASE_WORD) < 32'(DEPTH));
    endfunction

    function automatic int word_index(input logic [33:0] addr, input int k);
        logic [31:0] t;
        t = addr[33:2] - BASE_WORD + 32'(k);
        return int'(t % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] exp_read(input logic [33:0] addr, input int k);
        if (!in_window(addr)) return 32'd0;
        return mdl[word_index(addr, k)];
    endfunction

    function automatic void model_write(input logic [33:0] addr, input int k,
                                        input logic [31:0] d, input logic [3:0] be);
        int idx;
        if (!in_window(addr)) return;
        idx = word_index(addr, k);
        for (int i = 0; i < 4; i++)
            if (be[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
    endfunction

    task automatic do_write(input logic [33:0] addr, input logic [3:0] bc,
                            input logic [31:0] bubble_mask, input bit also_read);
        int b, beat, cyc, rv;
        b = (bc == 4'd0) ? 1 : int'(bc);
        beat = 0; cyc = 0; rv = 0;
        while (beat < b && cyc < 2000) begin
            @(negedge clk);
            if (m_readdatavalid) rv++;
            if (beat > 0 && bubble_mask[cyc % 32]) begin
                m_write = 1'b0;
                m_read  = 1'b0;
            end else begin
                m_write      = 1'b1;
                m_read       = (beat == 0) ? also_read : 1'b0;
                m_writedata  = wdata_buf[beat];
                m_byteenable = be_buf[beat];
                if (beat == 0) begin
                    m_address    = addr;
                    m_burstcount = bc;
                end else begin
                    m_address    = {$urandom, 2'b00};
                    m_burstcount = 4'($urandom);
                end
                if (!m_waitrequest) begin
                    model_write(addr, beat, wdata_buf[beat], be_buf[beat]);
                    beat++;
                end
            end
            cyc++;
        end
        if (beat < b) check_eq("wr_timeout", beat, b);
        @(negedge clk);
        m_write = 1'b0;
        m_read  = 1'b0;
        if (m_readdatavalid) rv++;
        check_eq("wr_no_rvalid", rv, 0);
    endtask

    task automatic do_read(input string tag, input logic [33:0] addr, input logic [3:0] bc);
        int b, got, cyc, lat, gaps, wr_hi;
        bit started;
        b = (bc == 4'd0) ? 1 : int'(bc);
        got = 0; cyc = 0; lat = 0; gaps = 0; wr_hi = 0; started = 1'b0;
        @(negedge clk);
        m_read = 1'b1; m_write = 1'b0; m_address = addr; m_burstcount = bc;
        while (m_waitrequest && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1000) begin
            check_eq({tag, "_accept_timeout"}, cyc, 0);
            m_read = 1'b0;
            return;
        end
`ifndef ARMLEOCPU_BURST_RAM_STALL_INJECT_EN
        check_eq({tag, "_accept_wait"}, cyc, 0);
`endif
        @(negedge clk);
        m_read = 1'b0;
        m_address = {$urandom, 2'b00};
        cyc = 0;
        forever begin
            if (m_readdatavalid) begin
                started = 1'b1;
                check_eq($sformatf("%s_beat%0d", tag, got), m_readdata, exp_read(addr, got));
                got++;
            end else if (started) gaps++;
            else lat++;
            if (m_waitrequest) wr_hi++;
            if (got >= b || cyc >= 1000) break;
            @(negedge clk);
            cyc++;
        end
        if (got < b) check_eq({tag, "_beat_timeout"}, got, b);
        @(negedge clk);
        check_eq({tag, "_no_extra"}, m_readdatavalid, 0);
`ifndef ARMLEOCPU_BURST_RAM_STALL_INJECT_EN
        check_eq({tag, "_latency"}, lat, 0);
        check_eq({tag, "_gaps"}, gaps, 0);
        check_eq({tag, "_wait_cycles"}, wr_hi, b - 1);
`endif
    endtask

    initial begin
        int got, cyc, extra;
        logic [33:0] a;
        logic [3:0]  bc;

        repeat (3) @(negedge clk);
        check_eq("reset_rvalid", m_readdatavalid, 0);
        check_eq("reset_rdata", m_readdata, 0);
`ifndef ARMLEOCPU_BURST_RAM_STALL_INJECT_EN
        check_eq("reset_wait", m_waitrequest, 0);
`endif
        rst_n = 1'b1;

        // Fill the whole window so every later read has a defined expectation.
        for (int blk = 0; blk < DEPTH / 8; blk++) begin
            for (int k = 0; k < 8; k++) begin
                wdata_buf[k] = $urandom;
                be_buf[k]    = 4'hF;
            end
            do_write(34'(blk * 32), 4'd8, 32'd0, 1'b0);
        end

        wdata_buf[0] = 32'hDEADBEEF; be_buf[0] = 4'hF;
        do_write(34'h10, 4'd1, 32'd0, 1'b0);
        do_read("single", 34'h10, 4'd1);

        for (int k = 0; k < 15; k++) begin
            wdata_buf[k] = 32'h100 + 32'(k);
            be_buf[k]    = 4'hF;
        end
        do_write(34'h40, 4'd15, 32'd0, 1'b0);
        do_read("burst15", 34'h40, 4'd15);

        wdata_buf[0] = 32'hFFFFFFFF; be_buf[0] = 4'hF;
        do_write(34'h20, 4'd1, 32'd0, 1'b0);
        wdata_buf[0] = 32'h11223344; be_buf[0] = 4'b0101;
        do_write(34'h20, 4'd1, 32'd0, 1'b0);
        do_read("byteen", 34'h20, 4'd1);

        for (int k = 0; k < 5; k++) begin
            wdata_buf[k] = 32'hAAAA0000 + 32'(k);
            be_buf[k]    = 4'hF;
        end
        do_write(34'h80, 4'd5, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) wdata_buf[k] = 32'h5000 + 32'(k);
        do_write(34'h80, 4'd4, 32'h0000000A, 1'b0);
        do_read("bubble", 34'h80, 4'd5);

        for (int k = 0; k < 3; k++) wdata_buf[k] = 32'hC0DE0000 + 32'(k);
        do_write(34'(4 * (DEPTH - 1)), 4'd3, 32'd0, 1'b0);
        do_read("wrap", 34'(4 * (DEPTH - 1)), 4'd3);
        do_read("wrap_w0", 34'h0, 4'd2);

        do_read("oor_read", 34'h190, 4'd2);
        wdata_buf[0] = 32'h0BADF00D; be_buf[0] = 4'hF;
        do_write(34'h190, 4'd1, 32'd0, 1'b0);
        do_read("oor_alias", 34'h90, 4'd1);

        wdata_buf[0] = 32'h600DCAFE; wdata_buf[1] = 32'h12345678;
        be_buf[0] = 4'hF; be_buf[1] = 4'hF;
        do_write(34'h30, 4'd2, 32'd0, 1'b1);
        do_read("rw_both", 34'h30, 4'd2);

        do_read("bc0", 34'h44, 4'd0);

        // Reset in the middle of a read burst.
        @(negedge clk);
        m_read = 1'b1; m_address = 34'h40; m_burstcount = 4'd8;
        cyc = 0;
        while (m_waitrequest && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        m_read = 1'b0;
        got = 0; cyc = 0;
        while (cyc < 1000) begin
            if (m_readdatavalid) begin
                if (got == 2) break;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_reached_beat2", got, 2);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_rvalid", m_readdatavalid, 0);
        check_eq("rst_mid_rdata", m_readdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_readdatavalid) extra++;
            @(negedge clk);
        end
        check_eq("rst_no_more_beats", extra, 0);
`ifndef ARMLEOCPU_BURST_RAM_STALL_INJECT_EN
        check_eq("rst_idle_wait", m_waitrequest, 0);
`endif
        do_read("post_rst", 34'h40, 4'd8);

        for (int op = 0; op < 30; op++) begin
            a  = 34'($urandom_range(0, DEPTH + 16 - 1) * 4 + $urandom_range(0, 3));
            bc = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 16; k++) begin
                    wdata_buf[k] = $urandom;
                    be_buf[k]    = 4'($urandom);
                end
                do_write(a, bc, ($urandom & $urandom) & 32'h7FFFFFFF, $urandom_range(0, 7) == 0);
            end else begin
                do_read($sformatf("rnd%0d", op), a, bc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/armleocpu_burst_ram.md
Name: armleocpu_burst_ram

Overview:
- Memory-side responder for the cache's 34-bit burst master bus (m_address/m_burstcount/m_read/m_write/m_waitrequest/m_readdatavalid).
- On-chip word RAM that accepts single and burst reads and writes.
- Returns read data one beat per cycle and honours byte enables.
- Serves as the simulation/FPGA backing store behind the cache and as the bench target for the cache refill and flush paths.

Parameters:
- DEPTH_W, 12, log2 of RAM depth in 32-bit words; byte capacity is 4*2^DEPTH_W.
- BASE_WORD, 0, word index, i.e. byte address >> 2, of the first RAM word. The window is BASE_WORD .. BASE_WORD+2^DEPTH_W-1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_address  input  34  byte address of the command's first beat; bits [1:0] are ignored.
- m_burstcount  input  4  beats in the burst, 1..15; the value 0 is treated as 1.
- m_waitrequest  output  1  high means the command or write beat is not accepted this cycle.
- m_read  input  1  read command.
- m_readdata  output  32  read beat data.
- m_readdatavalid  output  1  m_readdata valid this cycle.
- m_write  input  1  write beat; the first beat carries the command.
- m_writedata  input  32  write beat data.
- m_byteenable  input  4  per-byte write enable for the beat; ignored for reads.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, beat counter=0.
  - m_readdatavalid=0, m_readdata=0.
  - m_waitrequest is combinational from state, so it reads 0 in IDLE. RAM contents are not cleared.
  - Reset asserted mid-burst abandons the burst: no further readdatavalid, remaining write beats are not stored.
- States: IDLE, READ_BURST, WRITE_BURST. m_waitrequest=1 only in READ_BURST.
- Acceptance: a command is accepted in IDLE when (m_read|m_write) & !m_waitrequest.
  - If m_read and m_write are both high, the write is serviced and the read is dropped.
- Read, accepted in cycle N:
  - The RAM read of word w0 = m_address[33:2] is issued in cycle N.
  - Beat k (0..B-1) is presented at cycle N+1+k with m_readdatavalid=1. There are no gaps.
  - B>1: go to READ_BURST and issue one RAM read per cycle. Return to IDLE in the cycle the last read is issued.
  - A new command may be accepted in the cycle the last beat is presented. Its first beat follows the next cycle, so back-to-back beats have zero dead cycles.
  - m_read/m_write in READ_BURST are ignored; m_waitrequest=1.
- Write, accepted in cycle N:
  - Beat 0 is written to w0 in cycle N using m_byteenable.
  - B>1: go to WRITE_BURST with remaining=B-1 and m_waitrequest=0.
  - Each cycle with m_write=1 writes the next word and decrements remaining. Cycles with m_write=0 are bubbles and make no progress.
  - m_address/m_burstcount are ignored after beat 0. Go to IDLE after the last beat.
- Byte enables: byte lane i is written only if m_byteenable[i]. m_byteenable=0 is a legal no-op beat that still counts.
- Address arithmetic:
  - Beat k targets word index (w0 - BASE_WORD + k) modulo 2^DEPTH_W, so bursts wrap at the end of the RAM.
- Range:
  - A command whose w0 lies outside the window is out of range for its whole burst.
  - Reads complete with normal timing and return 0.
  - Writes complete normally and are discarded.
- Read-during-write to the same word (only possible across back-to-back commands) returns the old data.

Optional Feature:
- ARMLEOCPU_BURST_RAM_STALL_INJECT_EN
- Defined:
  - A free-running 16-bit LFSR (seed 16'hACE1 on reset) forces m_waitrequest=1 in IDLE/WRITE_BURST when lfsr[0]=1.
  - It also inserts a bubble in the read stream when lfsr[1]=1: the read pointer holds and m_readdatavalid=0 that cycle.
  - Beat order and data are unchanged.
- Undefined: the LFSR is absent and timing is exactly as above.

Decomposition:
- Shared package (armleocpu_defs.sv): burstcount width (4), bus address width (34), state localparams BURST_RAM_IDLE/READ_BURST/WRITE_BURST.
- Sub-module: storage is four byte-wide mem_1w1r instances, one per byte lane, with write = beat_write & m_byteenable[i]. The top holds the FSM, counters and range logic.

Test Plan:
- Reset, then single write addr=0x10, data=0xDEADBEEF, be=4'hF, then single read addr=0x10 -> waitrequest 0 at accept; readdatavalid exactly 1 cycle later with 0xDEADBEEF.
- 16-beat write burst: burstcount must be 15, since 16 is not representable, so use 15 beats of data 0x100+k at 0x40, then a read burst of 15 -> beats 0x100..0x10E on 15 consecutive cycles; waitrequest high for 14 cycles after accept.
- Write 0xFFFFFFFF, then be=4'b0101 with data 0x11223344 to the same address -> readback 0xFF22FF44.
- Write burst of 4 with m_write low on cycles 2 and 4 -> exactly 4 words stored; readback matches, with no extra or shifted words.
- Burst of 3 starting at the last RAM word -> beats land at words 2^DEPTH_W-1, 0, 1. Read of an out-of-range address -> 0 returned with normal timing.
- Assert rst_n low during beat 2 of a read burst of 8 -> m_readdatavalid drops immediately; after release state is IDLE and waitrequest 0. With the stall macro defined, repeat test 2 -> identical data and order.
